// File: rtl/instr_fetcher.sv
// instr_fetcher: byte-serial instruction fetch stage feeding instr_decoder.
// Reads one byte per memory transaction starting at the requested PC. Bytes
// are packed little-endian and the decoder is consulted after each byte.
// The finished instruction is then offered downstream over valid/ready.

`ifndef INSN_GROUP_NEED_MORE_BYTES
`define INSN_GROUP_NEED_MORE_BYTES 8'hFF
`endif

module instr_fetcher #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_data,
  input  logic                  mem_ack,
  output logic [31:0]           dec_instr,
  output logic [1:0]            dec_op_len,
  input  logic [2:0]            dec_len,
  input  logic [7:0]            dec_group,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [2:0]            out_len,
  output logic [7:0]            out_group,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH-1:0] out_next_pc
);

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned OPLEN_W  = 2;
  localparam int unsigned GROUP_W  = 8;
  localparam logic [CNT_W-1:0]   MAX_LEN    = 3'd4;
  localparam logic [OPLEN_W-1:0] MAX_OP_LEN = 2'd2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EVAL  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
  logic [INSTR_W-1:0]    instr_q,    instr_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [OPLEN_W-1:0]    op_len_q,   op_len_d;
  logic                  op_phase_q, op_phase_d;

  logic                  mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  out_valid_d;
  logic [INSTR_W-1:0]    out_instr_d;
  logic [CNT_W-1:0]      out_len_d;
  logic [GROUP_W-1:0]    out_group_d;
  logic [ADDR_WIDTH-1:0] out_pc_d;
  logic [ADDR_WIDTH-1:0] out_next_pc_d;

  logic [CNT_W-1:0]      len_clamp_c;

  // Decoder view is the captured bytes and the current opcode length.
  assign dec_instr  = instr_q;
  assign dec_op_len = op_len_q;

  // Decoder may report lengths beyond what a 32-bit word can hold.
  assign len_clamp_c = (dec_len > MAX_LEN) ? MAX_LEN : dec_len;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      cnt_q       <= '0;
      op_len_q    <= '0;
      op_phase_q  <= 1'b1;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_len     <= '0;
      out_group   <= '0;
      out_pc      <= '0;
      out_next_pc <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      cnt_q       <= cnt_d;
      op_len_q    <= op_len_d;
      op_phase_q  <= op_phase_d;
      mem_rd      <= mem_rd_d;
      mem_addr    <= mem_addr_d;
      out_valid   <= out_valid_d;
      out_instr   <= out_instr_d;
      out_len     <= out_len_d;
      out_group   <= out_group_d;
      out_pc      <= out_pc_d;
      out_next_pc <= out_next_pc_d;
    end
  end

  // Next-state and next-output logic; flush overrides every transition.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    cnt_d         = cnt_q;
    op_len_d      = op_len_q;
    op_phase_d    = op_phase_q;
    mem_rd_d      = mem_rd;
    mem_addr_d    = mem_addr;
    out_valid_d   = out_valid;
    out_instr_d   = out_instr;
    out_len_d     = out_len;
    out_group_d   = out_group;
    out_pc_d      = out_pc;
    out_next_pc_d = out_next_pc;

    if (flush) begin
      state_d     = S_IDLE;
      mem_rd_d    = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Late acks from an abandoned read land here and are ignored.
          if (start) begin
            pc_d       = pc_in;
            instr_d    = '0;
            cnt_d      = '0;
            op_len_d   = '0;
            op_phase_d = 1'b1;
            mem_rd_d   = 1'b1;
            mem_addr_d = pc_in;
            state_d    = S_FETCH;
          end
        end

        S_FETCH: begin
          // Request and address stay put until memory answers.
          if (mem_ack) begin
            instr_d[{cnt_q[1:0], 3'b000} +: 8] = mem_data;
            cnt_d    = cnt_q + 3'd1;
            mem_rd_d = 1'b0;
            if (op_phase_q) begin
              op_len_d = (op_len_q == MAX_OP_LEN) ? MAX_OP_LEN : op_len_q + 2'd1;
            end
            state_d = S_EVAL;
          end
        end

        S_EVAL: begin
          // Opcode is complete once the decoder stops asking or hits two bytes.
          if ((dec_group != `INSN_GROUP_NEED_MORE_BYTES) || (op_len_q == MAX_OP_LEN)) begin
            op_phase_d = 1'b0;
          end
          if (cnt_q < len_clamp_c) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = pc_q + ADDR_WIDTH'(cnt_q);
            state_d    = S_FETCH;
          end else begin
            out_valid_d   = 1'b1;
            out_instr_d   = instr_q;
            out_len_d     = cnt_q;
            out_group_d   = dec_group;
            out_pc_d      = pc_q;
            out_next_pc_d = pc_q + ADDR_WIDTH'(cnt_q);
            state_d       = S_OUT;
          end
        end

        S_OUT: begin
          // start is deliberately not looked at here.
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule
